// File: rtl/chime_alarm_ctrl.sv
// Hourly chime and daily alarm sequencer for the 100 Hz clock domain.
// Drives the buzzer enable and tone select from the running time of day.
module chime_alarm_ctrl #(
  parameter int BEEP_CYC   = 50,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       K0,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_minute,
  input  logic       SNZ,
  output logic       beep,
  output logic       tone_hi,
  output logic       ringing
);

  // state  | meaning
  // IDLE   | no alarm activity; chime may still beep
  // RING   | alarm sounding, ring timer running down
  // SNOOZE | alarm paused, snooze timer running down

  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam int WW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
  localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [6:0]    BEEP_LIM  = 7'(BEEP_CYC);
  localparam logic [6:0]    BEEP_LAST = 7'(BEEP_CYC - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SNOOZE_SEC - 1);
  localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t        state, state_nxt;
  logic [5:0]    sec_prev;
  logic [6:0]    phase;
  logic [1:0]    snz_sync;
  logic          chime_act, chime_hi;
  logic [RW-1:0] ring_left, ring_nxt;
  logic [WW-1:0] wait_left, wait_nxt;
  logic [SW-1:0] snz_cnt, snz_nxt;

  logic sec_evt, beep_win, snz_press, chime_arm, alarm_hit;

  assign sec_evt   = (second != sec_prev);
  assign beep_win  = (phase < BEEP_LIM);
  assign snz_press = snz_sync[1] & ~snz_sync[0];
  assign chime_arm = chime_en & ~K0 & (minute == 6'd59) &
                     (second inside {6'd51, 6'd53, 6'd55, 6'd57, 6'd59});
  assign alarm_hit = alarm_en & ~K0 & (second == 6'd0) &
                     (hour == alarm_hour) & (minute == alarm_minute);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_prev  <= '0;
      phase     <= '0;
      snz_sync  <= 2'b11;
      chime_act <= 1'b0;
      chime_hi  <= 1'b0;
    end else begin
      sec_prev <= second;
      snz_sync <= {snz_sync[0], SNZ};
      if (sec_evt)
        phase <= '0;
      else if (phase != 7'd127)
        phase <= phase + 7'd1;
      // a fresh second either re-arms the chime or cancels a stale one
      if (sec_evt) begin
        chime_act <= chime_arm;
        if (chime_arm)
          chime_hi <= (second == 6'd59);
      end else if (phase >= BEEP_LAST) begin
        chime_act <= 1'b0;
      end
    end
  end

  // timers hold seconds remaining and expire on the second event at zero
  always_comb begin
    state_nxt = state;
    ring_nxt  = ring_left;
    wait_nxt  = wait_left;
    snz_nxt   = snz_cnt;
    if (!alarm_en || K0) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sec_evt && alarm_hit) begin
            state_nxt = RING;
            ring_nxt  = RING_LAST;
            snz_nxt   = '0;
          end
        end
        RING: begin
          if (snz_press) begin
            if (snz_cnt < SNZ_MAX) begin
              state_nxt = SNOOZE;
              snz_nxt   = snz_cnt + SW'(1);
              wait_nxt  = WAIT_LAST;
            end else begin
              state_nxt = IDLE;
            end
          end else if (sec_evt) begin
            if (ring_left == '0)
              state_nxt = IDLE;
            else
              ring_nxt = ring_left - RW'(1);
          end
        end
        SNOOZE: begin
          if (sec_evt) begin
            if (wait_left == '0) begin
              state_nxt = RING;
              ring_nxt  = RING_LAST;
            end else begin
              wait_nxt = wait_left - WW'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ring_left <= '0;
      wait_left <= '0;
      snz_cnt   <= '0;
      beep      <= 1'b0;
      tone_hi   <= 1'b0;
      ringing   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ring_left <= ring_nxt;
      wait_left <= wait_nxt;
      snz_cnt   <= snz_nxt;
      ringing   <= (state == RING);
      beep      <= (state == RING) ? beep_win : (chime_act & beep_win);
      tone_hi   <= (state != RING) & chime_act & chime_hi;
    end
  end

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
// Directed bench for chime_alarm_ctrl: per-second vector table plus
// hand sequences for snooze, dismiss, chime/alarm overlap and reset.
module tb_chime_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       K0 = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] minute = '0;
  logic [5:0] second = '0;
  logic       chime_en = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] alarm_hour = 5'd7;
  logic [5:0] alarm_minute = 6'd30;
  logic       SNZ = 1'b1;
  logic       beep, tone_hi, ringing;

  int n_tests = 0;
  int n_fail  = 0;
  bit prev_ring = 1'b0;

  chime_alarm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .K0(K0), .hour(hour), .minute(minute),
    .second(second), .chime_en(chime_en), .alarm_en(alarm_en),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .SNZ(SNZ),
    .beep(beep), .tone_hi(tone_hi), .ringing(ringing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, m, s;
    bit ce, k0, ae;
    bit eb, eh, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int h, int m, int s, bit ce, bit k0, bit ae,
                              bit eb, bit eh, bit er);
    vec_t v;
    v.h = h; v.m = m; v.s = s; v.ce = ce; v.k0 = k0; v.ae = ae;
    v.eb = eb; v.eh = eh; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one second of time for 100 cycles; beep window is cycles 2..51
  // after the change, ringing reflects the previous second on cycle 1.
  task automatic apply(input vec_t v);
    bit win;
    hour = 5'(v.h); minute = 6'(v.m); second = 6'(v.s);
    chime_en = v.ce; K0 = v.k0; alarm_en = v.ae;
    for (int k = 1; k <= 100; k++) begin
      step();
      win = (k >= 2) && (k <= 51);
      chk($sformatf("beep %02d:%02d:%02d k=%0d", v.h, v.m, v.s, k), beep, v.eb && win);
      chk($sformatf("tone_hi %02d:%02d:%02d k=%0d", v.h, v.m, v.s, k), tone_hi, v.eh && win);
      chk($sformatf("ringing %02d:%02d:%02d k=%0d", v.h, v.m, v.s, k), ringing,
          (k == 1) ? prev_ring : v.er);
    end
    prev_ring = v.er;
  endtask

  // One-second advance in 5 cycles, for long snooze intervals.
  task automatic tick_fast();
    if (second == 6'd59) begin
      second = '0;
      if (minute == 6'd59) begin
        minute = '0;
        hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
      end else begin
        minute = minute + 6'd1;
      end
    end else begin
      second = second + 6'd1;
    end
    repeat (5) step();
  endtask

  task automatic press_snz();
    SNZ = 1'b0;
    repeat (3) step();
    SNZ = 1'b1;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit eb;
    // chime sweeps: enabled, disabled, then suppressed by time-set mode
    for (int r = 0; r < 3; r++) begin
      bit ce = (r != 1);
      bit k0 = (r == 2);
      for (int s = 50; s <= 59; s++) begin
        eb = ce && !k0 && (s == 51 || s == 53 || s == 55 || s == 57 || s == 59);
        tbl.push_back(mk(0, 59, s, ce, k0, 0, eb, eb && (s == 59), 0));
      end
      tbl.push_back(mk(1, 0, 0, ce, k0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 1, ce, k0, 0, 0, 0, 0));
    end
    // alarm 07:30 start
    tbl.push_back(mk(7, 29, 58, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7, 29, 59, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(7, 30, 0,  0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(7, 30, 1,  0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(7, 30, 2,  0, 0, 1, 1, 0, 1));

    repeat (3) step();
    chk("reset beep", beep, 1'b0);
    chk("reset tone_hi", tone_hi, 1'b0);
    chk("reset ringing", ringing, 1'b0);
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) apply(tbl[i]);

    // ring timeout after 60 seconds, no re-trigger in the following minute
    for (int s = 3; s <= 59; s++) apply(mk(7, 30, s, 0, 0, 1, 1, 0, 1));
    apply(mk(7, 31, 0, 0, 0, 1, 0, 0, 0));
    for (int s = 1; s <= 3; s++) apply(mk(7, 31, s, 0, 0, 1, 0, 0, 0));

    // next day it fires again
    apply(mk(7, 29, 59, 0, 0, 1, 0, 0, 0));
    apply(mk(7, 30, 0, 0, 0, 1, 1, 0, 1));

    // three snoozes, each re-ringing exactly 300 seconds later
    for (int n = 1; n <= 3; n++) begin
      press_snz();
      chk($sformatf("snooze%0d ringing off", n), ringing, 1'b0);
      if (n == 2) begin
        repeat (100) tick_fast();
        press_snz();
        chk("press ignored in snooze", ringing, 1'b0);
        repeat (199) tick_fast();
      end else begin
        repeat (299) tick_fast();
      end
      chk($sformatf("snooze%0d still quiet at 299s", n), ringing, 1'b0);
      tick_fast();
      chk($sformatf("snooze%0d re-ring at 300s", n), ringing, 1'b1);
    end
    press_snz();
    chk("4th press dismiss", ringing, 1'b0);
    repeat (305) tick_fast();
    chk("no re-ring after dismiss", ringing, 1'b0);
    prev_ring = 1'b0;

    // alarm ringing through the chime seconds overrides the chime
    alarm_hour = 5'd0; alarm_minute = 6'd59;
    apply(mk(0, 58, 59, 1, 0, 1, 0, 0, 0));
    apply(mk(0, 59, 0,  1, 0, 1, 1, 0, 1));
    apply(mk(0, 59, 54, 1, 0, 1, 1, 0, 1));
    apply(mk(0, 59, 55, 1, 0, 1, 1, 0, 1));
    second = 6'd56;
    repeat (10) step();
    chk("overlap ringing", ringing, 1'b1);
    chk("overlap beep", beep, 1'b1);
    alarm_en = 1'b0;
    repeat (2) step();
    chk("disarm ringing", ringing, 1'b0);
    chk("disarm beep", beep, 1'b0);
    chk("disarm tone_hi", tone_hi, 1'b0);

    // asynchronous reset while ringing, released at second 0
    alarm_hour = 5'd7; alarm_minute = 6'd30; chime_en = 1'b0;
    prev_ring = 1'b0;
    apply(mk(7, 29, 59, 0, 0, 1, 0, 0, 0));
    hour = 5'd7; minute = 6'd30; second = 6'd0;
    repeat (10) step();
    chk("pre-reset ringing", ringing, 1'b1);
    chk("pre-reset beep", beep, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset beep", beep, 1'b0);
    chk("mid reset tone_hi", tone_hi, 1'b0);
    chk("mid reset ringing", ringing, 1'b0);
    repeat (3) step();
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("post reset ringing k=%0d", k), ringing, 1'b0);
      chk($sformatf("post reset beep k=%0d", k), beep, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
